// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - animation frame scheduler (rate, range, playback mode, single-step) with MMIO control
// Optional FRAME_SEQ_REV_SYNC_EN: frame changes are held pending and committed on rev_pulse.
module frame_sequencer #(
  parameter int unsigned NUM_FRAMES  = 75,
  parameter int unsigned FRAME_SIZE  = 3328,
  parameter int unsigned DEFAULT_DIV = 6666667,
  parameter int unsigned OFFSET_W    = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  input  logic                rev_pulse,
  output logic [7:0]          frame_idx,
  output logic [OFFSET_W-1:0] frame_offset,
  output logic                frame_tick
);
  typedef enum logic [1:0] {MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG, MODE_HOLD} mode_e;

  localparam logic [7:0] LAST        = 8'(NUM_FRAMES - 1);
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DIV    = 3'd1;
  localparam logic [2:0] ADDR_START  = 3'd2;
  localparam logic [2:0] ADDR_END    = 3'd3;
  localparam logic [2:0] ADDR_STEP   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic                run_q, run_d;
  mode_e               mode_q, mode_d;
  logic [31:0]         div_q, div_d, timer_q, timer_d;
  logic [7:0]          start_q, start_d, end_q, end_d, idx_q, idx_d;
  logic                dir_q, dir_d, done_q, done_d, step_q, step_d, tick_q, tick_d;
  logic [OFFSET_W-1:0] off_q, off_d;

  logic                adv, do_adv;
  logic [7:0]          base, nxt;
  logic [OFFSET_W-1:0] nxt_off;

`ifdef FRAME_SEQ_REV_SYNC_EN
  logic                pend_vld_q, pend_vld_d;
  logic [7:0]          pend_idx_q, pend_idx_d;
  logic [OFFSET_W-1:0] pend_off_q, pend_off_d;
`else
  logic                unused_rev_pulse;
  assign unused_rev_pulse = rev_pulse;
`endif

  function automatic logic [7:0] clamp_idx(input logic [7:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  always_comb begin
    run_d   = run_q;
    mode_d  = mode_q;
    div_d   = div_q;
    start_d = start_q;
    end_d   = end_q;
    done_d  = done_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    adv     = step_q;
    if (cfg_we) begin
      case (cfg_addr)
        ADDR_CTRL: begin
          run_d  = cfg_wdata[0];
          mode_d = mode_e'(cfg_wdata[2:1]);
        end
        ADDR_DIV:    div_d   = cfg_wdata;
        ADDR_START:  start_d = clamp_idx(cfg_wdata[7:0]);
        ADDR_END:    end_d   = clamp_idx(cfg_wdata[7:0]);
        ADDR_STEP:   step_d  = ~run_q;
        ADDR_STATUS: if (cfg_wdata[8]) done_d = 1'b0;
        default: ;
      endcase
    end

    // Timer sees the freshly written RUN so a CTRL write wins over a same-cycle terminal count
    if (cfg_we && cfg_addr == ADDR_DIV) begin
      timer_d = '0;
    end else if (run_d && div_q != 32'd0) begin
      if (timer_q >= div_q - 32'd1) begin
        timer_d = '0;
        adv     = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end

`ifdef FRAME_SEQ_REV_SYNC_EN
    base = pend_vld_q ? pend_idx_q : idx_q;
`else
    base = idx_q;
`endif
    do_adv = adv && (mode_d != MODE_HOLD);
    nxt    = base;
    dir_d  = dir_q;
    if (do_adv) begin
      if (start_q > end_q || base < start_q || base > end_q) begin
        nxt   = start_q;
        dir_d = 1'b0;
      end else begin
        case (mode_d)
          MODE_LOOP: nxt = (base >= end_q) ? start_q : base + 8'd1;
          MODE_ONESHOT: begin
            if (base >= end_q) begin
              done_d = 1'b1;
              if (!step_q) run_d = 1'b0;
            end else begin
              nxt = base + 8'd1;
            end
          end
          MODE_PINGPONG: begin
            if (start_q != end_q) begin
              if (!dir_q) begin
                if (base >= end_q) begin
                  dir_d = 1'b1;
                  nxt   = base - 8'd1;
                end else begin
                  nxt = base + 8'd1;
                end
              end else if (base <= start_q) begin
                dir_d = 1'b0;
                nxt   = base + 8'd1;
              end else begin
                nxt = base - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
    // Constant-coefficient product feeds the register, never the output path
    nxt_off = OFFSET_W'(32'(nxt) * FRAME_SIZE);

    idx_d  = idx_q;
    off_d  = off_q;
    tick_d = 1'b0;
`ifdef FRAME_SEQ_REV_SYNC_EN
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    pend_off_d = pend_off_q;
    if (do_adv) begin
      pend_vld_d = 1'b1;
      pend_idx_d = nxt;
      pend_off_d = nxt_off;
    end
    if (rev_pulse && pend_vld_d) begin
      idx_d      = pend_idx_d;
      off_d      = pend_off_d;
      tick_d     = (pend_idx_d != idx_q);
      pend_vld_d = 1'b0;
    end
`else
    if (do_adv) begin
      idx_d  = nxt;
      off_d  = nxt_off;
      tick_d = (nxt != idx_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b1;
      mode_q  <= MODE_LOOP;
      div_q   <= DEFAULT_DIV;
      start_q <= '0;
      end_q   <= LAST;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
      timer_q <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      start_q <= start_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      tick_q  <= tick_d;
    end
  end

`ifdef FRAME_SEQ_REV_SYNC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      pend_off_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      pend_off_q <= pend_off_d;
    end
  end
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata = {29'd0, mode_q, run_q};
      ADDR_DIV:    cfg_rdata = div_q;
      ADDR_START:  cfg_rdata = {24'd0, start_q};
      ADDR_END:    cfg_rdata = {24'd0, end_q};
      ADDR_STATUS: cfg_rdata = {22'd0, dir_q, done_q, idx_q};
      default:     cfg_rdata = '0;
    endcase
  end

  assign frame_idx    = idx_q;
  assign frame_offset = off_q;
  assign frame_tick   = tick_q;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Replaces the free-running animation frame counter feeding the texture ROM address path.
- Schedules which frame the mapper reads: programmable frame rate, frame range and playback mode, single-step control.
- CPU configures it through a small MMIO register window.
- Outputs frame_idx and a precomputed frame_offset, so the ROM address becomes frame_offset + led*TEX_WIDTH + col.

Parameters:
NUM_FRAMES, 75, frames stored in texture ROM
FRAME_SIZE, 3328, pixels per frame (TEX_WIDTH*LED_COUNT)
DEFAULT_DIV, 6666667, reset cycles-per-frame (100 MHz / 15 fps)
OFFSET_W, 18, width of frame_offset (clog2(FRAME_SIZE*NUM_FRAMES))

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
cfg_we  input  1  register write strobe, one cycle
cfg_addr  input  3  register select
cfg_wdata  input  32  write data
cfg_rdata  output  32  read data, combinational from cfg_addr
rev_pulse  input  1  one-cycle pulse at revolution boundary (theta wrap)
frame_idx  output  8  current frame, 0..NUM_FRAMES-1
frame_offset  output  OFFSET_W  frame_idx*FRAME_SIZE, registered alongside frame_idx
frame_tick  output  1  one-cycle pulse in the cycle frame_idx changes

Behaviour:
- Reset (reset low, async):
  - frame_idx=0, frame_offset=0, frame_tick=0.
  - RUN=1, MODE=LOOP, DIV=DEFAULT_DIV, START=0, END=NUM_FRAMES-1, dir=up, DONE=0, timer=0.
- Registers:
  - 0 CTRL: [0] RUN, [2:1] MODE (0 LOOP, 1 ONESHOT, 2 PINGPONG, 3 HOLD).
  - 1 DIV: 32-bit.
  - 2 START: [7:0].
  - 3 END: [7:0].
  - 4 STEP: write-only, any value.
  - 5 STATUS: read {dir[9], DONE[8], frame_idx[7:0]}; writing bit8=1 clears DONE.
  - Other addresses read 0 and ignore writes.
- START/END writes clamp to NUM_FRAMES-1.
- Timer:
  - Counts only while RUN=1 and DIV!=0.
  - At timer==DIV-1: timer<=0 and an advance event occurs.
  - DIV=0 stops ticks.
  - Writing DIV resets the timer to 0.
- Advance, with next frame computed from the current frame:
  - LOOP: idx>=END -> START, else +1.
  - ONESHOT: idx>=END -> hold, RUN<=0, DONE<=1; else +1.
  - PINGPONG:
    - up: idx>=END -> dir=down, idx-1 (if START==END, hold).
    - down: idx<=START -> dir=up, idx+1.
  - HOLD: no change, no frame_tick.
  - idx outside [START,END] at advance: idx<=START, dir=up.
  - START>END: idx<=START and holds there.
- STEP:
  - Applied only when RUN=0: one advance event in the next cycle.
  - When RUN=1, STEP is ignored.
  - Uses the MODE rules, except ONESHOT at END only sets DONE.
- Update timing:
  - frame_idx, frame_offset and frame_tick update together, one cycle after the advance event.
  - Latency from timer terminal count to new frame_idx is 1 cycle.
- frame_offset arithmetic:
  - Computed from the next index in the same registered update; never a multiplier on the output path.
  - Must not exceed FRAME_SIZE*(NUM_FRAMES-1).
- Same-cycle CTRL write and advance event: the CTRL write takes effect first; the advance uses the new MODE/RUN.
- Reset asserted mid-playback returns all state to reset values immediately.

Optional Feature:
- Macro: FRAME_SEQ_REV_SYNC_EN.
- Defined (tear-free frame change):
  - Advance events update an internal pending frame only.
  - frame_idx, frame_offset and frame_tick commit on the next rev_pulse.
  - Multiple advances before rev_pulse chain on the pending value; latest wins.
  - rev_pulse with nothing pending does nothing.
  - STATUS[7:0] still returns the committed frame_idx.
- Not defined: rev_pulse is ignored and frames commit immediately as above.

Test Plan:
- Reset release, DIV=4, LOOP, START=0, END=2 -> frame_idx 0,1,2,0 with frame_tick every 4 cycles; frame_offset 0,3328,6656,0.
- ONESHOT, START=5, END=7, DIV=3 -> 5,6,7 then hold; RUN reads 0, DONE=1; write STATUS bit8 -> DONE=0.
- PINGPONG, START=10, END=12, DIV=2 -> 10,11,12,11,10,11; STATUS dir bit toggles at 12 and 10.
- RUN=0, three STEP writes in LOOP with END=74 from frame 73 -> 74, 0, ...; STEP with RUN=1 -> no change.
- Write END=200 -> reads 74; START=20 while idx=3 -> next advance gives 20; DIV=0 -> frame frozen for 1000 cycles.
- With FRAME_SEQ_REV_SYNC_EN, DIV=2, rev_pulse every 7 cycles -> frame_idx changes only the cycle after each rev_pulse, skipping to the latest pending frame.
